// File: rtl/reflet_int_ctrl.sv
// Prioritised, nestable interrupt controller: picks the highest-priority enabled
// request, saves {return address, level} on a LIFO context stack on entry, restores on return.
module reflet_int_ctrl #(
   parameter int wordsize = 16,
   parameter int nb_int   = 8,
   parameter int depth    = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         enable,
   input  logic [nb_int-1:0]            ext_int,
   input  logic [nb_int-1:0]            int_mask,
   input  logic [nb_int-1:0]            edge_mode,
   input  logic                         setint_we,
   input  logic [$clog2(nb_int)-1:0]    setint_idx,
   input  logic [wordsize-1:0]          setint_addr,
   input  logic [wordsize-1:0]          program_counter,
   input  logic                         cpu_update,
   input  logic                         retint,
   output logic                         interrupt,
   output logic [wordsize-1:0]          out_routine,
   output logic [wordsize-1:0]          ret_addr,
   output logic [$clog2(nb_int+1)-1:0]  level,
   output logic                         stack_err
);
   localparam int idx_w = $clog2(nb_int);
   localparam int lvl_w = $clog2(nb_int + 1);
   localparam int cnt_w = $clog2(depth + 1);
   localparam int sp_w  = (depth > 1) ? $clog2(depth) : 1;

   logic [nb_int-1:0]   ext_prev_reg, pend_reg, pend_next;
   logic [nb_int-1:0]   pending, rise, clear;
   logic [wordsize-1:0] routine_reg [nb_int];
   logic [wordsize-1:0] stk_addr_reg [depth];
   logic [lvl_w-1:0]    stk_lvl_reg [depth];
   logic [cnt_w-1:0]    count_reg;
   logic [lvl_w-1:0]    level_reg, target;
   logic                stack_err_reg;
   logic                full, empty, want_int, do_ret;
   logic [sp_w-1:0]     push_idx, top_idx;

   // Edge channels use the latched bit, level channels follow the input directly.
   assign rise    = ext_int & ~ext_prev_reg;
   assign pending = (edge_mode & pend_reg) | (~edge_mode & ext_int);

   always_comb begin
      target = lvl_w'(nb_int);
      for (int i = nb_int - 1; i >= 0; i--) begin
         if (pending[i] && int_mask[i]) target = lvl_w'(i);
      end
   end

   assign full      = (count_reg == cnt_w'(depth));
   assign empty     = (count_reg == '0);
   assign want_int  = enable && cpu_update && (target < level_reg);
   assign interrupt = want_int && !full;
   assign do_ret    = enable && cpu_update && retint && !interrupt;

   assign push_idx = count_reg[sp_w-1:0];
   assign top_idx  = push_idx - sp_w'(1);

   always_comb begin
      clear = '0;
      if (interrupt) clear[target[idx_w-1:0]] = 1'b1;
      // A fresh rising edge wins over the clear of the channel being serviced.
      pend_next = ((pend_reg & ~clear) | rise) & edge_mode;
   end

   assign out_routine = (target == lvl_w'(nb_int)) ? '0 : routine_reg[target[idx_w-1:0]];
   assign ret_addr    = empty ? '0 : stk_addr_reg[top_idx];
   assign level       = level_reg;
   assign stack_err   = stack_err_reg;

   always_ff @(posedge clk) begin
      if (!reset) begin
         ext_prev_reg  <= '0;
         pend_reg      <= '0;
         level_reg     <= lvl_w'(nb_int);
         count_reg     <= '0;
         stack_err_reg <= 1'b0;
      end else if (enable) begin
         ext_prev_reg <= ext_int;
         pend_reg     <= pend_next;
         if (interrupt) begin
            level_reg <= target;
            count_reg <= count_reg + cnt_w'(1);
         end else if (do_ret && !empty) begin
            level_reg <= stk_lvl_reg[top_idx];
            count_reg <= count_reg - cnt_w'(1);
         end
         if ((want_int && full) || (do_ret && empty)) stack_err_reg <= 1'b1;
      end
   end

   // Stack contents need no reset: the count alone defines what is valid.
   always_ff @(posedge clk) begin
      if (reset && interrupt) begin
         stk_addr_reg[push_idx] <= program_counter;
         stk_lvl_reg[push_idx]  <= level_reg;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < nb_int; gi++) begin : g_routine
         always_ff @(posedge clk) begin
            if (!reset)
               routine_reg[gi] <= '0;
            else if (enable && setint_we && (setint_idx == idx_w'(gi)))
               routine_reg[gi] <= setint_addr;
         end
      end
   endgenerate
endmodule

// File: tb/tb_reflet_int_ctrl.sv
// Directed bench for reflet_int_ctrl (8 channels, 2-deep stack) with hand-computed expectations.
module tb_reflet_int_ctrl;
   logic        clk = 1'b0;
   logic        reset, enable, setint_we, cpu_update, retint;
   logic [7:0]  ext_int, int_mask, edge_mode;
   logic [2:0]  setint_idx;
   logic [15:0] setint_addr, program_counter;
   logic        interrupt, stack_err;
   logic [15:0] out_routine, ret_addr;
   logic [3:0]  level;
   int errors = 0;
   int checks = 0;

   reflet_int_ctrl #(.wordsize(16), .nb_int(8), .depth(2)) dut (
      .clk(clk), .reset(reset), .enable(enable), .ext_int(ext_int),
      .int_mask(int_mask), .edge_mode(edge_mode), .setint_we(setint_we),
      .setint_idx(setint_idx), .setint_addr(setint_addr),
      .program_counter(program_counter), .cpu_update(cpu_update), .retint(retint),
      .interrupt(interrupt), .out_routine(out_routine), .ret_addr(ret_addr),
      .level(level), .stack_err(stack_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_routine(input logic [2:0] idx, input logic [15:0] addr);
      setint_we = 1'b1; setint_idx = idx; setint_addr = addr;
      tick();
      setint_we = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; cpu_update = 1'b0; retint = 1'b0; ext_int = 8'h00;
      tick(); tick();
      reset = 1'b1; #1;
      checks++; if (level !== 4'd8) begin errors++; $display("FAIL reset_level: got %0d want 8", level); end
      checks++; if (ret_addr !== 16'h0) begin errors++; $display("FAIL reset_ret_addr: got %h want 0000", ret_addr); end
      checks++; if (out_routine !== 16'h0) begin errors++; $display("FAIL reset_out_routine: got %h want 0000", out_routine); end
      checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL reset_interrupt: got %b want 0", interrupt); end
      checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL reset_stack_err: got %b want 0", stack_err); end
      $display("reset: level=%0d ret_addr=%h stack_err=%b", level, ret_addr, stack_err);
   endtask

   task automatic test_level_nest();
      write_routine(3'd2, 16'h0120);
      write_routine(3'd0, 16'h0200);
      write_routine(3'd5, 16'h0500);
      int_mask = 8'hFF; edge_mode = 8'h00;
      ext_int = 8'h04; program_counter = 16'h0040; cpu_update = 1'b1; #1;
      checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL nest_take2_int: got %b want 1", interrupt); end
      checks++; if (out_routine !== 16'h0120) begin errors++; $display("FAIL nest_take2_routine: got %h want 0120", out_routine); end
      tick(); cpu_update = 1'b0; #1;
      checks++; if (level !== 4'd2) begin errors++; $display("FAIL nest_level2: got %0d want 2", level); end
      checks++; if (ret_addr !== 16'h0040) begin errors++; $display("FAIL nest_ret_addr2: got %h want 0040", ret_addr); end
      $display("enter ch2: level=%0d ret_addr=%h", level, ret_addr);
      ext_int = 8'h24; cpu_update = 1'b1; #1;
      checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL nest_low_prio_int: got %b want 0", interrupt); end
      tick();
      ext_int = 8'h25; program_counter = 16'h0130; #1;
      checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL nest_take0_int: got %b want 1", interrupt); end
      checks++; if (out_routine !== 16'h0200) begin errors++; $display("FAIL nest_take0_routine: got %h want 0200", out_routine); end
      tick();
      checks++; if (level !== 4'd0) begin errors++; $display("FAIL nest_level0: got %0d want 0", level); end
      checks++; if (ret_addr !== 16'h0130) begin errors++; $display("FAIL nest_ret_addr0: got %h want 0130", ret_addr); end
      $display("enter ch0: level=%0d ret_addr=%h", level, ret_addr);
      ext_int = 8'h00; retint = 1'b1; #1;
      checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL ret1_int: got %b want 0", interrupt); end
      tick();
      checks++; if (level !== 4'd2) begin errors++; $display("FAIL ret1_level: got %0d want 2", level); end
      checks++; if (ret_addr !== 16'h0040) begin errors++; $display("FAIL ret1_ret_addr: got %h want 0040", ret_addr); end
      tick();
      checks++; if (level !== 4'd8) begin errors++; $display("FAIL ret2_level: got %0d want 8", level); end
      checks++; if (ret_addr !== 16'h0000) begin errors++; $display("FAIL ret2_ret_addr: got %h want 0000", ret_addr); end
      $display("returns: level=%0d ret_addr=%h", level, ret_addr);
      retint = 1'b0; cpu_update = 1'b0;
   endtask

   task automatic test_edge();
      write_routine(3'd3, 16'h0330);
      edge_mode = 8'h08;
      ext_int = 8'h08; tick(); ext_int = 8'h00;
      tick(); tick(); tick();
      checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL edge_no_update_int: got %b want 0", interrupt); end
      cpu_update = 1'b1; program_counter = 16'h0050; #1;
      checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL edge_take_int: got %b want 1", interrupt); end
      checks++; if (out_routine !== 16'h0330) begin errors++; $display("FAIL edge_take_routine: got %h want 0330", out_routine); end
      tick();
      checks++; if (level !== 4'd3) begin errors++; $display("FAIL edge_level3: got %0d want 3", level); end
      retint = 1'b1; tick(); retint = 1'b0; #1;
      checks++; if (level !== 4'd8) begin errors++; $display("FAIL edge_ret_level: got %0d want 8", level); end
      checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL edge_no_reentry: got %b want 0", interrupt); end
      $display("edge pulse: serviced once, level=%0d", level);
      // Latch an edge, then present a fresh edge on the very cycle it is serviced.
      cpu_update = 1'b0;
      ext_int = 8'h08; tick(); ext_int = 8'h00; tick();
      cpu_update = 1'b1; ext_int = 8'h08; #1;
      checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL edge2_take_int: got %b want 1", interrupt); end
      tick();
      ext_int = 8'h00; retint = 1'b1; tick(); retint = 1'b0; #1;
      checks++; if (level !== 4'd8) begin errors++; $display("FAIL edge2_ret_level: got %0d want 8", level); end
      checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL edge2_kept_pending: got %b want 1", interrupt); end
      tick();
      retint = 1'b1; tick(); retint = 1'b0; cpu_update = 1'b0; #1;
      checks++; if (level !== 4'd8) begin errors++; $display("FAIL edge2_final_level: got %0d want 8", level); end
      $display("edge set-and-clear: pending kept, re-entered, level=%0d", level);
      edge_mode = 8'h00;
   endtask

   task automatic test_enable();
      enable = 1'b0; ext_int = 8'h04; cpu_update = 1'b1; #1;
      checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL dis_int: got %b want 0", interrupt); end
      write_routine(3'd2, 16'hBEEF);
      checks++; if (level !== 4'd8) begin errors++; $display("FAIL dis_level: got %0d want 8", level); end
      enable = 1'b1; #1;
      checks++; if (out_routine !== 16'h0120) begin errors++; $display("FAIL dis_write_ignored: got %h want 0120", out_routine); end
      // Routine write and interrupt on the same cycle: the old address is presented.
      setint_we = 1'b1; setint_idx = 3'd2; setint_addr = 16'h0777; program_counter = 16'h0060; #1;
      checks++; if (out_routine !== 16'h0120) begin errors++; $display("FAIL wr_same_cycle_old: got %h want 0120", out_routine); end
      tick(); setint_we = 1'b0; #1;
      checks++; if (level !== 4'd2) begin errors++; $display("FAIL wr_same_cycle_level: got %0d want 2", level); end
      checks++; if (out_routine !== 16'h0777) begin errors++; $display("FAIL wr_same_cycle_new: got %h want 0777", out_routine); end
      $display("enable/write: out_routine=%h level=%0d", out_routine, level);
      retint = 1'b1; ext_int = 8'h00; tick(); retint = 1'b0; cpu_update = 1'b0;
   endtask

   task automatic test_empty_pop();
      cpu_update = 1'b1; retint = 1'b1; ext_int = 8'h00; #1;
      checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL empty_int: got %b want 0", interrupt); end
      tick(); cpu_update = 1'b0; retint = 1'b0; #1;
      checks++; if (level !== 4'd8) begin errors++; $display("FAIL empty_level: got %0d want 8", level); end
      checks++; if (stack_err !== 1'b1) begin errors++; $display("FAIL empty_stack_err: got %b want 1", stack_err); end
      $display("empty pop: level=%0d stack_err=%b", level, stack_err);
   endtask

   task automatic test_overflow_then_reset();
      ext_int = 8'h40; program_counter = 16'h0070; cpu_update = 1'b1; tick();
      checks++; if (level !== 4'd6) begin errors++; $display("FAIL ovf_level6: got %0d want 6", level); end
      ext_int = 8'h42; program_counter = 16'h0080; tick();
      checks++; if (level !== 4'd1) begin errors++; $display("FAIL ovf_level1: got %0d want 1", level); end
      ext_int = 8'h43; #1;
      checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL ovf_int_blocked: got %b want 0", interrupt); end
      checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL ovf_err_before: got %b want 0", stack_err); end
      tick(); cpu_update = 1'b0; #1;
      checks++; if (stack_err !== 1'b1) begin errors++; $display("FAIL ovf_stack_err: got %b want 1", stack_err); end
      checks++; if (level !== 4'd1) begin errors++; $display("FAIL ovf_level_held: got %0d want 1", level); end
      checks++; if (ret_addr !== 16'h0080) begin errors++; $display("FAIL ovf_ret_addr: got %h want 0080", ret_addr); end
      $display("overflow: level=%0d stack_err=%b ret_addr=%h", level, stack_err, ret_addr);
      reset = 1'b0; ext_int = 8'h00; tick();
      checks++; if (level !== 4'd8) begin errors++; $display("FAIL midreset_level: got %0d want 8", level); end
      checks++; if (ret_addr !== 16'h0000) begin errors++; $display("FAIL midreset_ret_addr: got %h want 0000", ret_addr); end
      checks++; if (out_routine !== 16'h0000) begin errors++; $display("FAIL midreset_out_routine: got %h want 0000", out_routine); end
      checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL midreset_stack_err: got %b want 0", stack_err); end
      $display("mid-nesting reset: level=%0d ret_addr=%h", level, ret_addr);
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0; enable = 1'b1; setint_we = 1'b0; setint_idx = 3'd0; setint_addr = 16'h0;
      program_counter = 16'h0; cpu_update = 1'b0; retint = 1'b0;
      ext_int = 8'h00; int_mask = 8'hFF; edge_mode = 8'h00;
      test_reset();
      test_level_nest();
      test_edge();
      test_enable();
      test_empty_pop();
      test_reset();
      test_overflow_then_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/reflet_int_ctrl.md
REFLET_INT_CTRL -- requirements
Module: reflet_int_ctrl

Interface
REQ-001 SHALL have parameter wordsize, default 16, data and address width.
REQ-002 SHALL have parameter nb_int, default 8, number of interrupt channels (2..16).
REQ-003 SHALL have parameter depth, default 8, maximum nesting depth of the context stack (1..16).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 enable  input  1  global enable; when low, all state holds, except that reset still applies.
REQ-007 ext_int  input  nb_int  interrupt request lines; bit 0 has the highest priority.
REQ-008 int_mask  input  nb_int  per-channel enable; 1 means enabled.
REQ-009 edge_mode  input  nb_int  per-channel mode; 1 means rising-edge-latched, 0 means level.
REQ-010 setint_we  input  1  write strobe for the routine table.
REQ-011 setint_idx  input  clog2(nb_int)  routine table index.
REQ-012 setint_addr  input  wordsize  routine address to write.
REQ-013 program_counter  input  wordsize  return address pushed on entry.
REQ-014 cpu_update  input  1  CPU instruction boundary; interrupts are taken only here.
REQ-015 retint  input  1  current instruction is a return-from-interrupt.
REQ-016 interrupt  output  1  take interrupt now (combinational).
REQ-017 out_routine  output  wordsize  routine address of the winning channel (combinational).
REQ-018 ret_addr  output  wordsize  top-of-stack return address, or 0 when the stack is empty.
REQ-019 level  output  clog2(nb_int+1)  current context; the value nb_int means normal (non-interrupt) context.
REQ-020 stack_err  output  1  sticky flag for overflow-block or empty-pop events.

Function
REQ-021 pending[i] SHALL track channel i as follows:
- Edge mode: set on a rising edge of ext_int[i], detected against a one-cycle registered copy of ext_int.
- Level mode: equals ext_int[i] combinationally.
REQ-022 target SHALL be the lowest index i with pending[i] & int_mask[i]; target SHALL be nb_int when no such i exists.
REQ-023 interrupt SHALL be high when all of the following hold: enable, cpu_update, target < level, and the stack is not full.
REQ-024 If target < level and cpu_update is high but the stack holds depth entries, interrupt SHALL stay low and stack_err SHALL set.
REQ-025 On interrupt, at the next edge the block SHALL:
- push {program_counter, level} onto the stack;
- set level <= target;
- clear pending[target] if that channel is in edge mode.
REQ-026 An edge-mode rising edge on the same cycle its bit is cleared SHALL keep the bit set.
REQ-027 A return SHALL fire when cpu_update & retint & enable are high and interrupt is low. On a return, at the next edge the stack SHALL pop and level SHALL take the popped level.
REQ-028 When interrupt and retint coincide, the interrupt SHALL win and the return SHALL not occur that cycle.
REQ-029 A return on an empty stack SHALL be ignored, level SHALL be unchanged, and stack_err SHALL set.
REQ-030 out_routine SHALL equal routines[target], or 0 when target = nb_int.
REQ-031 With setint_we and enable high, routines[setint_idx] SHALL take setint_addr at the next edge; an index >= nb_int SHALL be ignored.
REQ-032 A setint write and an interrupt on the same cycle SHALL present the old routine on out_routine; the new value is visible the next cycle.
REQ-033 The stack SHALL be a LIFO of depth entries with a count register of width clog2(depth+1). Push and pop never occur in the same cycle.

Reset
REQ-034 On reset low at a clock edge, the block SHALL set:
- level = nb_int;
- stack count = 0;
- pending = 0;
- the registered ext_int copy = 0;
- routines = 0;
- stack_err = 0.
REQ-035 Reset SHALL override enable and any in-progress nesting.
REQ-036 After reset: interrupt = 0 unless a level-mode masked request is present, out_routine = 0, ret_addr = 0.

Verification
REQ-037 Set routines[2] = 0x0120, mask = 0xFF, edge_mode = 0, hold ext_int[2] = 1, pulse cpu_update with program_counter = 0x0040 -> interrupt = 1, out_routine = 0x0120, next cycle level = 2, ret_addr = 0x0040.
REQ-038 While at level 2, assert ext_int[5] -> interrupt = 0; then assert ext_int[0] with program_counter = 0x0130 -> nesting to level 0; retint -> level = 2, ret_addr = 0x0040; second retint -> level = 8.
REQ-039 Edge mode on channel 3: 1-cycle pulse on ext_int[3] while cpu_update = 0, then cpu_update 3 cycles later -> interrupt taken, pending[3] clears; with no further edge, no re-entry after retint.
REQ-040 depth = 2, nest two interrupts, request a third with higher priority -> interrupt = 0, stack_err = 1, level unchanged.
REQ-041 retint with an empty stack -> level = 8, stack_err = 1.
REQ-042 Assert reset mid-nesting at level 1 -> next cycle level = 8, ret_addr = 0, out_routine = 0.
